// File: rtl/prefetch_fill_ctrl_pkg.sv
// Shared definitions for the prefetch FIFO fill sequencer.
package prefetch_fill_ctrl_pkg;

  // Length codes carried by fault markers in the prefetch FIFO.
  localparam logic [3:0] PREFETCH_GP_FAULT = 4'd15;
  localparam logic [3:0] PREFETCH_PF_FAULT = 4'd14;

  // Default sizing of the downstream FIFO and the issue threshold.
  localparam int unsigned DEF_FIFO_DEPTH     = 16;
  localparam int unsigned DEF_ISSUE_MAX_USED = DEF_FIFO_DEPTH - 4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWait  = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } fill_state_e;

endpackage

// File: rtl/prefetch_fill_ctrl_pack.sv
// Per-beat packing: byte offset, entry length and right-aligned data.
module prefetch_fill_ctrl_pack (
  input  logic [1:0]  addr_lo_i,
  input  logic [32:0] remaining_i,
  input  logic [31:0] data_i,
  output logic [3:0]  len_o,
  output logic [31:0] data_o
);

  logic [2:0] room;

  // Length is the bytes left in this dword, clipped by the remaining limit.
  always_comb begin
    room = 3'd4 - {1'b0, addr_lo_i};
    if (remaining_i < {30'd0, room}) begin
      len_o = {1'b0, remaining_i[2:0]};
    end else begin
      len_o = {1'b0, room};
    end
    data_o = data_i >> {addr_lo_i, 3'b000};
  end

endmodule

// File: rtl/prefetch_fill_ctrl.sv
// Fills the instruction prefetch FIFO from aligned 16-byte line reads.
module prefetch_fill_ctrl
  import prefetch_fill_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int unsigned ISSUE_MAX_USED = DEF_ISSUE_MAX_USED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pr_reset,
  input  logic        start_do,
  input  logic [31:0] start_address,
  input  logic [31:0] start_limit_remaining,
  input  logic [4:0]  prefetchfifo_used,
  output logic        mem_req,
  output logic [31:0] mem_address,
  input  logic        mem_ack,
  input  logic        mem_data_valid,
  input  logic [31:0] mem_data,
  input  logic        mem_data_last,
  input  logic        mem_pf,
  output logic        prefetchfifo_write_do,
  output logic [35:0] prefetchfifo_write_data,
  output logic        prefetchfifo_signal_limit_do,
  output logic        prefetchfifo_signal_pf_do,
  output logic        busy
);

  localparam logic [4:0] IssueMax = 5'(ISSUE_MAX_USED);
  localparam logic [4:0] DepthW   = 5'(FIFO_DEPTH);

  fill_state_e state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [32:0] remaining_q, remaining_d;
  logic [1:0]  beat_q, beat_d;
  logic        start_pend_q, start_pend_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        write_do_q, write_do_d;
  logic [35:0] write_data_q, write_data_d;
  logic        limit_do_q, limit_do_d;
  logic        pf_do_q, pf_do_d;

  logic [3:0]  pack_len;
  logic [31:0] pack_data;
  logic        line_end;
  logic        line_done;
  logic        acked;
  logic        beat_use;

  prefetch_fill_ctrl_pack u_pack (
    .addr_lo_i   (cur_addr_q[1:0]),
    .remaining_i (remaining_q),
    .data_i      (mem_data),
    .len_o       (pack_len),
    .data_o      (pack_data)
  );

  // Next-state, stream bookkeeping and registered FIFO/memory strobes.
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    beat_d        = beat_q;
    start_pend_d  = start_pend_q;
    mem_req_d     = mem_req_q;
    mem_address_d = mem_address_q;
    write_do_d    = 1'b0;
    write_data_d  = '0;
    limit_do_d    = 1'b0;
    pf_do_d       = 1'b0;

    line_end  = mem_data_valid && mem_data_last;
    line_done = line_end || mem_pf;
    acked     = mem_req_q && mem_ack;
    // A beat is used only when it holds the next wanted byte and budget is left.
    beat_use  = (beat_q == cur_addr_q[3:2]) && (remaining_q != 33'd0);

    unique case (state_q)
      StIdle, StDone: begin
        if (pr_reset) begin
          state_d = StIdle;
        end else if (start_do) begin
          cur_addr_d  = start_address;
          remaining_d = {1'b0, start_limit_remaining} + 33'd1;
          state_d     = StIssue;
        end
      end

      StIssue: begin
        if (pr_reset) begin
          mem_req_d    = 1'b0;
          start_pend_d = 1'b0;
          state_d      = acked ? StDrain : StIdle;
        end else if (start_do) begin
          cur_addr_d  = start_address;
          remaining_d = {1'b0, start_limit_remaining} + 33'd1;
          mem_req_d   = 1'b0;
          if (acked) begin
            start_pend_d = 1'b1;
            state_d      = StDrain;
          end
        end else if (mem_req_q) begin
          if (mem_ack) begin
            mem_req_d = 1'b0;
            beat_d    = 2'd0;
            state_d   = StWait;
          end
        end else if (remaining_q == 33'd0) begin
          // Marker still needs a free FIFO slot.
          if (prefetchfifo_used < DepthW) begin
            limit_do_d   = 1'b1;
            write_data_d = {PREFETCH_GP_FAULT, 32'd0};
            state_d      = StDone;
          end
        end else if (prefetchfifo_used <= IssueMax) begin
          mem_req_d     = 1'b1;
          mem_address_d = {cur_addr_q[31:4], 4'b0000};
        end
      end

      StWait: begin
        if (pr_reset) begin
          start_pend_d = 1'b0;
          state_d      = line_done ? StIdle : StDrain;
        end else if (start_do) begin
          cur_addr_d   = start_address;
          remaining_d  = {1'b0, start_limit_remaining} + 33'd1;
          start_pend_d = !line_done;
          state_d      = line_done ? StIssue : StDrain;
        end else if (mem_pf) begin
          pf_do_d      = 1'b1;
          write_data_d = {PREFETCH_PF_FAULT, 32'd0};
          state_d      = StDone;
        end else if (mem_data_valid) begin
          beat_d = beat_q + 2'd1;
          if (beat_use) begin
            write_do_d   = 1'b1;
            write_data_d = {pack_len, pack_data};
            remaining_d  = remaining_q - {29'd0, pack_len};
            cur_addr_d   = cur_addr_q + {28'd0, pack_len};
          end
          if (mem_data_last) begin
            state_d = StIssue;
          end
        end
      end

      StDrain: begin
        // A flush here keeps draining the in-flight line but cancels any latched start.
        if (pr_reset) begin
          start_pend_d = 1'b0;
        end else if (start_do) begin
          cur_addr_d   = start_address;
          remaining_d  = {1'b0, start_limit_remaining} + 33'd1;
          start_pend_d = 1'b1;
        end
        if (line_done) begin
          state_d      = start_pend_d ? StIssue : StIdle;
          start_pend_d = 1'b0;
        end
      end

      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      beat_q        <= '0;
      start_pend_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_address_q <= '0;
      write_do_q    <= 1'b0;
      write_data_q  <= '0;
      limit_do_q    <= 1'b0;
      pf_do_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      beat_q        <= beat_d;
      start_pend_q  <= start_pend_d;
      mem_req_q     <= mem_req_d;
      mem_address_q <= mem_address_d;
      write_do_q    <= write_do_d;
      write_data_q  <= write_data_d;
      limit_do_q    <= limit_do_d;
      pf_do_q       <= pf_do_d;
    end
  end

  assign mem_req                      = mem_req_q;
  assign mem_address                  = mem_address_q;
  assign prefetchfifo_write_do        = write_do_q;
  assign prefetchfifo_write_data      = write_data_q;
  assign prefetchfifo_signal_limit_do = limit_do_q;
  assign prefetchfifo_signal_pf_do    = pf_do_q;
  assign busy                         = (state_q != StIdle);

endmodule

// File: tb/tb_prefetch_fill_ctrl.sv
// Randomized scoreboard bench for prefetch_fill_ctrl.
module tb_prefetch_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pr_reset = 1'b0;
  logic        start_do = 1'b0;
  logic [31:0] start_address = '0;
  logic [31:0] start_limit_remaining = '0;
  logic [4:0]  prefetchfifo_used = '0;
  logic        mem_req;
  logic [31:0] mem_address;
  logic        mem_ack = 1'b0;
  logic        mem_data_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic        mem_data_last = 1'b0;
  logic        mem_pf = 1'b0;
  logic        wr_do;
  logic [35:0] wr_data;
  logic        lim_do;
  logic        pf_do;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Expected FIFO-side events: kind 0 data entry, 1 limit marker, 2 page-fault marker.
  typedef struct {
    int          kind;
    logic [35:0] data;
  } exp_t;
  exp_t exp_q[$];

  // kind: 0 run to limit, 1 page fault on line l, 2 abort at line l before beat k.
  // mode (abort): 0 flush, 1 flush then start in drain, 2 abort by start_do.
  typedef struct {
    logic [31:0] start;
    logic [31:0] limit;
    int          kind;
    int          l;
    int          k;
    int          mode;
  } ep_t;

  localparam int NumEp = 40;
  ep_t eps[NumEp];

  int used_model = 0;
  bit pop_en = 1'b0;
  int max_used = 0;

  always #5 clk = ~clk;

  prefetch_fill_ctrl dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .pr_reset                     (pr_reset),
    .start_do                     (start_do),
    .start_address                (start_address),
    .start_limit_remaining        (start_limit_remaining),
    .prefetchfifo_used            (prefetchfifo_used),
    .mem_req                      (mem_req),
    .mem_address                  (mem_address),
    .mem_ack                      (mem_ack),
    .mem_data_valid               (mem_data_valid),
    .mem_data                     (mem_data),
    .mem_data_last                (mem_data_last),
    .mem_pf                       (mem_pf),
    .prefetchfifo_write_do        (wr_do),
    .prefetchfifo_write_data      (wr_data),
    .prefetchfifo_signal_limit_do (lim_do),
    .prefetchfifo_signal_pf_do    (pf_do),
    .busy                         (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory contents: a fixed hash of the dword address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Entries for the byte range [start, start+count): split at dword boundaries,
  // each carrying its dword shifted down to the first wanted byte.
  task automatic push_chunks(input logic [31:0] start, input longint count);
    logic [31:0] p;
    longint      left;
    int          off;
    int          len;
    exp_t        e;
    p    = start;
    left = count;
    while (left > 0) begin
      off    = int'(p[1:0]);
      len    = (left < longint'(4 - off)) ? int'(left) : (4 - off);
      e.kind = 0;
      e.data = {4'(len), mem_word({p[31:2], 2'b00}) >> (8 * off)};
      exp_q.push_back(e);
      p    = p + 32'(len);
      left = left - longint'(len);
    end
  endtask

  function automatic longint lines_of(input logic [31:0] start, input logic [31:0] limit);
    return (longint'(start[3:0]) + longint'(limit) + 1 + 15) / 16;
  endfunction

  // Monitor and FIFO occupancy model.
  initial begin
    int   n;
    int   act_kind;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        n = int'(wr_do) + int'(lim_do) + int'(pf_do);
        if (n != 0) begin
          check("one_strobe", 64'(n), 64'd1);
          act_kind = wr_do ? 0 : (lim_do ? 1 : 2);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_push: kind %0d data %0h with nothing expected", act_kind,
                     wr_data);
          end else begin
            e = exp_q.pop_front();
            check("push_kind", 64'(act_kind), 64'(e.kind));
            if (e.kind == 0) check("push_data", 64'(wr_data), 64'(e.data));
          end
          used_model += n;
        end
      end
      if (pop_en && used_model > 0 && $urandom_range(1, 0) == 1) used_model--;
      if (used_model > max_used) max_used = used_model;
      prefetchfifo_used = 5'(used_model);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] lim);
    start_do              = 1'b1;
    start_address         = a;
    start_limit_remaining = lim;
    tick();
    start_do = 1'b0;
  endtask

  task automatic wait_queue_empty(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_episode(input ep_t e, input ep_t nxt, input bit started,
                             output bit restarted);
    longint      n;
    longint      cnt;
    longint      lines;
    int          off;
    bit          ok;
    bit          req_low;
    logic [31:0] base;
    logic [31:0] line_addr;
    exp_t        m;
    restarted = 1'b0;
    n    = longint'(e.limit) + 1;
    off  = int'(e.start[3:0]);
    base = {e.start[31:4], 4'b0000};
    if (e.kind == 0) cnt = n;
    else if (e.kind == 1) cnt = longint'(16 * e.l - off);
    else cnt = longint'(16 * e.l + 4 * e.k - off);
    if (cnt < 0) cnt = 0;
    if (cnt > n) cnt = n;
    push_chunks(e.start, cnt);
    if (e.kind != 2) begin
      m.kind = (e.kind == 0) ? 1 : 2;
      m.data = '0;
      exp_q.push_back(m);
    end
    if (!started) pulse_start(e.start, e.limit);
    lines = (e.kind == 0) ? lines_of(e.start, e.limit) : longint'(e.l + 1);

    for (int l = 0; l < int'(lines); l++) begin
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (mem_req) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      if (!ok) begin
        fail_now("req_timeout");
        pr_reset = 1'b1;
        tick();
        pr_reset = 1'b0;
        repeat (4) tick();
        exp_q.delete();
        return;
      end
      line_addr = base + 32'(16 * l);
      check("mem_address", 64'(mem_address), 64'(line_addr));
      repeat ($urandom_range(2, 0)) tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      if (e.kind == 1 && l == e.l) begin
        repeat ($urandom_range(2, 0)) tick();
        mem_pf = 1'b1;
        tick();
        mem_pf = 1'b0;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (e.kind == 2 && l == e.l && b == e.k) begin
            if (e.mode == 2) begin
              start_do              = 1'b1;
              start_address         = nxt.start;
              start_limit_remaining = nxt.limit;
              restarted             = 1'b1;
            end else begin
              pr_reset = 1'b1;
            end
            tick();
            start_do = 1'b0;
            pr_reset = 1'b0;
            if (e.mode == 1) begin
              pulse_start(nxt.start, nxt.limit);
              restarted = 1'b1;
            end
          end
          repeat ($urandom_range(1, 0)) tick();
          mem_data_valid = 1'b1;
          mem_data       = mem_word(line_addr + 32'(4 * b));
          mem_data_last  = (b == 3);
          tick();
          mem_data_valid = 1'b0;
          mem_data_last  = 1'b0;
        end
      end
    end

    if (e.kind != 2) begin
      wait_queue_empty(ok);
      if (!ok) begin
        fail_now("marker_timeout");
        exp_q.delete();
      end
      req_low = 1'b1;
      repeat (6) begin
        tick();
        if (mem_req) req_low = 1'b0;
      end
      check("done_no_req", 64'(req_low), 64'd1);
      check("done_busy", 64'(busy), 64'd1);
    end else if (e.mode == 0) begin
      repeat (2) tick();
      wait_queue_empty(ok);
      if (!ok) begin
        fail_now("flush_timeout");
        exp_q.delete();
      end
      check("flush_idle_busy", 64'(busy), 64'd0);
      check("flush_idle_req", 64'(mem_req), 64'd0);
    end
  endtask

  initial begin
    bit     started;
    bit     restarted;
    bit     req_low;
    longint nl;
    ep_t    r;

    // Directed episodes, then randomized ones.
    eps[0] = '{start: 32'h0000_1000, limit: 32'h0000_FFFF, kind: 2, l: 1, k: 0, mode: 0};
    eps[1] = '{start: 32'h0000_1006, limit: 32'h0000_FFFF, kind: 1, l: 1, k: 0, mode: 0};
    eps[2] = '{start: 32'h0000_2000, limit: 32'd5,         kind: 0, l: 0, k: 0, mode: 0};
    eps[3] = '{start: 32'h0000_3000, limit: 32'h40,        kind: 1, l: 0, k: 0, mode: 0};
    eps[4] = '{start: 32'h0000_4000, limit: 32'h0000_FFFF, kind: 2, l: 0, k: 1, mode: 1};
    eps[5] = '{start: 32'hFFFF_FFF6, limit: 32'hFFFF_FFFF, kind: 2, l: 2, k: 2, mode: 2};
    for (int i = 6; i < NumEp; i++) begin
      r.start = $urandom;
      if ($urandom_range(7, 0) == 0) begin
        r.limit = 32'hFFFF_FFFF;
        r.kind  = int'($urandom_range(2, 1));
      end else begin
        r.limit = 32'($urandom_range(70, 0));
        r.kind  = int'($urandom_range(2, 0));
      end
      if (i == NumEp - 1) begin
        r.limit = 32'($urandom_range(70, 0));
        r.kind  = 0;
      end
      nl   = lines_of(r.start, r.limit);
      if (nl > 4) nl = 4;
      r.l    = int'($urandom_range(32'(nl - 1), 0));
      r.k    = int'($urandom_range(3, 0));
      r.mode = int'($urandom_range(2, 0));
      eps[i] = r;
    end

    // Reset state.
    repeat (3) tick();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_address", 64'(mem_address), 64'd0);
    check("rst_write_do", 64'(wr_do), 64'd0);
    check("rst_write_data", 64'(wr_data), 64'd0);
    check("rst_limit_do", 64'(lim_do), 64'd0);
    check("rst_pf_do", 64'(pf_do), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick();

    // Throttle: occupancy 13 holds the request off, 12 releases it.
    used_model = 13;
    tick();
    pulse_start(32'h0000_5000, 32'h0000_FFFF);
    req_low = 1'b1;
    repeat (8) begin
      tick();
      if (mem_req) req_low = 1'b0;
    end
    check("throttle_hold", 64'(req_low), 64'd1);
    used_model = 12;
    @(negedge clk);
    check("throttle_not_early", 64'(mem_req), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("throttle_release", 64'(mem_req), 64'd1);
    check("throttle_address", 64'(mem_address), 64'h5000);
    tick();
    pr_reset = 1'b1;
    tick();
    pr_reset = 1'b0;
    tick();
    check("unacked_flush_req", 64'(mem_req), 64'd0);
    check("unacked_flush_busy", 64'(busy), 64'd0);
    used_model = 0;
    pop_en     = 1'b1;
    tick();

    started = 1'b0;
    for (int i = 0; i < NumEp; i++) begin
      run_episode(eps[i], (i + 1 < NumEp) ? eps[i + 1] : eps[i], started, restarted);
      started = restarted;
    end

    repeat (10) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("fifo_no_overflow", 64'(max_used <= 16), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prefetch_fill_ctrl.md
Name: prefetch_fill_ctrl

Overview:
Sequences the fill of the 16-entry instruction prefetch FIFO. It takes a start linear address and a CS limit, issues aligned 16-byte line reads to the code memory port, and packs returned dwords into FIFO entries of the form {length[3:0], data[31:0]}. It throttles on FIFO occupancy and terminates the stream with a limit-fault or page-fault marker. It sits between the prefetch address logic and the prefetch FIFO, and drives the FIFO's write, limit-signal and page-fault-signal inputs.

Parameters:
FIFO_DEPTH, 16, prefetch FIFO entry count.
ISSUE_MAX_USED, 12, highest prefetchfifo_used value at which a new line request is issued (FIFO_DEPTH-4).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
pr_reset  in  1  pipeline flush; aborts the stream
start_do  in  1  one-cycle pulse: begin a stream at start_address
start_address  in  32  linear address of the first instruction byte
start_limit_remaining  in  32  bytes allowed from start_address, minus 1 (limit - offset)
prefetchfifo_used  in  5  FIFO occupancy {full, usedw[3:0]}
mem_req  out  1  line read request, held until mem_ack
mem_address  out  32  line address, bits [3:0] = 0
mem_ack  in  1  request accepted
mem_data_valid  in  1  one returned dword valid
mem_data  in  32  returned dword, little-endian
mem_data_last  in  1  marks the 4th dword of the line
mem_pf  in  1  page fault on the request; replaces the data beats; single cycle
prefetchfifo_write_do  out  1  push data entry
prefetchfifo_write_data  out  36  {length, data}
prefetchfifo_signal_limit_do  out  1  push GP-fault marker
prefetchfifo_signal_pf_do  out  1  push PF-fault marker
busy  out  1  state != IDLE

Behaviour:
- Reset: on rst_n=0 at a clk edge, the state goes to IDLE. All outputs are 0 and remaining is 0.
- All FIFO-side outputs are registered and update one cycle after the causing input. No more than one of the three push strobes is asserted in a cycle.
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- IDLE -> ISSUE on start_do. On that edge:
  - cur_addr <= start_address.
  - remaining <= {1'b0, start_limit_remaining} + 1 (33-bit).
- ISSUE:
  - If remaining == 0: pulse signal_limit_do, then go to DONE.
  - Else if prefetchfifo_used <= ISSUE_MAX_USED: assert mem_req with mem_address = {cur_addr[31:4], 4'b0}. Stay in ISSUE until mem_ack, then go to WAIT.
- WAIT, per mem_data_valid beat, where beat index = count of beats received on this line (0..3):
  - A beat whose dword lies wholly below cur_addr[3:2] is dropped.
  - For the first used dword: off = cur_addr[1:0], else off = 0.
  - len = min(4 - off, remaining).
  - Data pushed = mem_data >> (8*off), upper bytes zero.
  - write_do = 1, write_data = {len[3:0], shifted data}.
  - remaining -= len; cur_addr += len.
  - If remaining reaches 0, later beats of this line are dropped.
  - On mem_data_last: go to ISSUE. The next line starts at the updated cur_addr.
- mem_pf in WAIT: pulse signal_pf_do, then go to DONE. No data beats follow.
- DONE: holds with no further requests or pushes until pr_reset or start_do.
  - start_do in DONE behaves as in IDLE.
- pr_reset, any state:
  - Pushes in the same cycle are suppressed.
  - From WAIT, or from ISSUE with mem_req asserted and mem_ack in the same cycle: go to DRAIN.
  - From ISSUE with a request held but no ack: mem_req drops, go to IDLE.
  - Otherwise go to IDLE.
- DRAIN: discard beats until mem_data_last or mem_pf, then go to IDLE. A start_do received in DRAIN is latched and taken on exit by going to ISSUE.
- start_do while busy, outside DRAIN: restarts as from IDLE. Any in-flight line is drained first by going through DRAIN with the start latched.
- Overflow safety: at most one request is outstanding, so the FIFO never exceeds 16 entries, including the fault marker.
- Address wrap: cur_addr wraps modulo 2^32.

Decomposition:
- PREFETCH_GP_FAULT and PREFETCH_PF_FAULT (4-bit length codes) stay in defines.v.
- Add the state encodings (3 bits) and ISSUE_MAX_USED default to defines.v.
- One natural sub-module, prefetch_fill_pack: combinational off/len/shift computation from cur_addr[1:0], remaining and mem_data.

Test Plan:
1. Aligned stream: start_address=0x1000, start_limit_remaining=0xFFFF -> mem_address=0x1000. Four pushes with length 4, then the next request is at 0x1010.
2. Unaligned start: start_address=0x1006, mem_data beat1=0xAABBCCDD -> beat0 dropped; first push {4'd2, 0x0000AABB}, then length-4 pushes for beats 2 and 3.
3. Limit mid-line: start_address=0x2000, start_limit_remaining=5 -> pushes of length 4 and 2. The remaining beats are dropped, then one signal_limit_do cycle. No further mem_req.
4. Page fault: mem_pf after mem_ack -> exactly one signal_pf_do, state DONE, busy=1, no mem_req until start_do.
5. Flush mid-line: pr_reset after beat 1 of 4 -> no pushes for beats 2-4, and DRAIN ends on mem_data_last. start_do in DRAIN causes mem_req one cycle after exit.
6. Throttle: prefetchfifo_used=13 -> mem_req stays 0. When it drops to 12, mem_req rises the next cycle.
